// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: run-control states, condition codes
// and the opcode that marks a condition (branch) instruction.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Condition codes evaluated against reg3 interpreted as signed 8-bit
    typedef enum logic [2:0] {
        CC_NEVER  = 3'b000,
        CC_EQ     = 3'b001,
        CC_LT     = 3'b010,
        CC_LE     = 3'b011,
        CC_ALWAYS = 3'b100,
        CC_NE     = 3'b101,
        CC_GE     = 3'b110,
        CC_GT     = 3'b111
    } cond_code_t;

    localparam logic [1:0] OP_COND = 2'b11;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage and its surroundings: run control, program
// load port, register feedback and the instruction stream to Calculations.
interface instruction_fetch_if;
    import fetch_pkg::*;

    // Handshake: inst carries a real instruction exactly in cycles where
    // inst_valid is high; there is no ready, the consumer takes one per cycle.
    logic         start;
    logic         stop;
    logic         prog_we;
    logic [7:0]   prog_addr;
    logic [7:0]   prog_data;
    logic [7:0]   reg0;
    logic [7:0]   reg3;
    logic [7:0]   inst;
    logic         inst_valid;
    logic [7:0]   pc;
    logic         halted;
    fetch_state_t state;

    modport master (
        output start, stop, prog_we, prog_addr, prog_data, reg0, reg3,
        input  inst, inst_valid, pc, halted, state
    );

    modport slave (
        input  start, stop, prog_we, prog_addr, prog_data, reg0, reg3,
        output inst, inst_valid, pc, halted, state
    );

endinterface

// File: rtl/condition_unit.sv
// Combinational branch-condition evaluator: decides whether a condition
// code holds for a signed 8-bit operand.
module condition_unit
    import fetch_pkg::*;
(
    input  logic [2:0] code,
    input  logic [7:0] value,
    output logic       take
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == 8'h00);
    assign is_neg  = value[7];

    always_comb begin
        take = 1'b0;
        case (cond_code_t'(code))
            CC_NEVER:  take = 1'b0;
            CC_EQ:     take = is_zero;
            CC_LT:     take = is_neg;
            CC_LE:     take = is_neg | is_zero;
            CC_ALWAYS: take = 1'b1;
            CC_NE:     take = ~is_zero;
            CC_GE:     take = ~is_neg;
            CC_GT:     take = ~is_neg & ~is_zero;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program store, program counter and run-control FSM feeding Calculations;
// condition instructions redirect the PC to reg0 with no delay slot.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input logic                clk,
    input logic                rst,
    instruction_fetch_if.slave bus
);

    // DEPTH must stay 256: the 8-bit PC addresses the whole store and wraps.
    logic [7:0]   mem [DEPTH];
    fetch_state_t state;
    logic [7:0]   pc_q;
    logic [7:0]   fetched;
    logic         take;
    logic         jump;

    assign fetched = (state == ST_RUN) ? mem[pc_q] : 8'h00;

    condition_unit u_cond (
        .code  (fetched[2:0]),
        .value (bus.reg3),
        .take  (take)
    );

    assign jump = (fetched[7:6] == OP_COND) && take;

    // Store is deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (rst && (state == ST_IDLE) && bus.prog_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            pc_q  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                        pc_q  <= 8'h00;
                    end
                end
                ST_RUN: begin
                    // stop outranks any jump or self-loop halt
                    if (bus.stop) begin
                        state <= ST_IDLE;
                    end else if (jump) begin
                        if (bus.reg0 == pc_q) begin
                            state <= ST_HALT;
                        end else begin
                            pc_q <= bus.reg0;
                        end
                    end else begin
                        pc_q <= pc_q + 8'd1;
                    end
                end
                ST_HALT: begin
                    if (bus.stop) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.inst       = fetched;
    assign bus.inst_valid = (state == ST_RUN);
    assign bus.pc         = pc_q;
    assign bus.halted     = (state == ST_HALT);
    assign bus.state      = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed program runs, expected {pc, inst}
// pairs queued by the driver and checked by an independent monitor.
module tb_instruction_fetch;
    import fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(.DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Queue the output expected in the cycle after the coming edge, then
    // advance to the middle of that cycle.
    task automatic tick(input bit v, input logic [7:0] p, input logic [7:0] i);
        if (v) exp_q.push_back({p, i});
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick(1'b0, 8'h00, 8'h00);
        bus.prog_we   = 1'b0;
    endtask

    task automatic queue_empty(input string name);
        check8(name, 8'(exp_q.size()), 8'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.inst_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc=%h inst=%h expected no valid output",
                             bus.pc, bus.inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    check8("stream_pc", bus.pc, mon_e[15:8]);
                    check8("stream_inst", bus.inst, mon_e[7:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.prog_we = 1'b0;
        bus.prog_addr = 8'h00; bus.prog_data = 8'h00;
        bus.reg0 = 8'h00; bus.reg3 = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check8("reset_pc", bus.pc, 8'h00);
        check8("reset_inst", bus.inst, 8'h00);
        check1("reset_valid", bus.inst_valid, 1'b0);
        check1("reset_halted", bus.halted, 1'b0);
        rst = 1'b1;

        // Phase 1: straight line, jumps, signed conditions, self-loop halt
        load(8'h00, 8'h05); load(8'h01, 8'h44); load(8'h02, 8'h81); load(8'h03, 8'hC4);
        load(8'h10, 8'hC1); load(8'h11, 8'hC1); load(8'h20, 8'hC2); load(8'h30, 8'hC2);
        load(8'h31, 8'hC7); load(8'h40, 8'hFF); load(8'h41, 8'hC0); load(8'h42, 8'hC3);
        load(8'h50, 8'hC5); load(8'h51, 8'hC6); load(8'h52, 8'hC4);

        bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h05);
        bus.start = 1'b0;
        tick(1'b1, 8'h01, 8'h44);
        tick(1'b1, 8'h02, 8'h81);
        tick(1'b1, 8'h03, 8'hC4);
        bus.reg0 = 8'h10;                       // always -> 0x10
        tick(1'b1, 8'h10, 8'hC1);
        bus.reg3 = 8'h01;                       // ==0 false
        tick(1'b1, 8'h11, 8'hC1);
        bus.reg3 = 8'h00; bus.reg0 = 8'h20;     // ==0 true
        tick(1'b1, 8'h20, 8'hC2);
        bus.reg3 = 8'h80; bus.reg0 = 8'h30;     // -128 < 0 true
        tick(1'b1, 8'h30, 8'hC2);
        bus.reg3 = 8'h7F;                       // 127 < 0 false; write ignored in RUN
        bus.prog_we = 1'b1; bus.prog_addr = 8'h01; bus.prog_data = 8'hAA;
        tick(1'b1, 8'h31, 8'hC7);
        bus.prog_we = 1'b0;
        bus.reg3 = 8'h01; bus.reg0 = 8'h40;     // 1 > 0 true
        tick(1'b1, 8'h40, 8'hFF);
        bus.reg3 = 8'h00;                       // 0 > 0 false, bits 5:3 ignored
        tick(1'b1, 8'h41, 8'hC0);
        bus.reg0 = 8'h50;                       // never
        tick(1'b1, 8'h42, 8'hC3);
        bus.reg3 = 8'h00; bus.reg0 = 8'h50;     // 0 <= 0 true
        tick(1'b1, 8'h50, 8'hC5);
        bus.reg3 = 8'h00;                       // 0 != 0 false
        tick(1'b1, 8'h51, 8'hC6);
        bus.reg3 = 8'hFF;                       // -1 >= 0 false
        tick(1'b1, 8'h52, 8'hC4);
        bus.reg0 = 8'h52;                       // jump to self -> HALT
        tick(1'b0, 8'h00, 8'h00);
        check1("halt1_halted", bus.halted, 1'b1);
        check1("halt1_valid", bus.inst_valid, 1'b0);
        check8("halt1_inst", bus.inst, 8'h00);
        check8("halt1_pc", bus.pc, 8'h52);
        bus.start = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.start = 1'b0;
        check1("halt_start_ignored", bus.halted, 1'b1);
        check8("halt_pc_frozen", bus.pc, 8'h52);
        bus.stop = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.stop = 1'b0;
        check1("halt_stop_halted", bus.halted, 1'b0);
        check1("halt_stop_valid", bus.inst_valid, 1'b0);
        queue_empty("phase1_queue");

        // Phase 2: stop beats a taken jump; store unchanged by the RUN write
        bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h05);
        bus.start = 1'b0;
        tick(1'b1, 8'h01, 8'h44);
        tick(1'b1, 8'h02, 8'h81);
        tick(1'b1, 8'h03, 8'hC4);
        bus.reg0 = 8'h10; bus.stop = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.stop = 1'b0;
        check1("stop_valid", bus.inst_valid, 1'b0);
        check8("stop_pc_held", bus.pc, 8'h03);
        check8("stop_inst", bus.inst, 8'h00);
        queue_empty("phase2_queue");

        // Phase 3: write+start together, reset mid-run at pc 7
        load(8'h03, 8'h01); load(8'h04, 8'h02); load(8'h05, 8'h03);
        load(8'h06, 8'h04); load(8'h07, 8'h05);
        bus.prog_we = 1'b1; bus.prog_addr = 8'h00; bus.prog_data = 8'h06; bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h06);
        bus.prog_we = 1'b0; bus.start = 1'b0;
        tick(1'b1, 8'h01, 8'h44);
        tick(1'b1, 8'h02, 8'h81);
        tick(1'b1, 8'h03, 8'h01);
        tick(1'b1, 8'h04, 8'h02);
        tick(1'b1, 8'h05, 8'h03);
        tick(1'b1, 8'h06, 8'h04);
        tick(1'b1, 8'h07, 8'h05);
        rst = 1'b0;
        tick(1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        check1("rst_mid_valid", bus.inst_valid, 1'b0);
        check8("rst_mid_pc", bus.pc, 8'h00);
        tick(1'b0, 8'h00, 8'h00);
        check1("rst_stays_idle", bus.inst_valid, 1'b0);
        bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h06);
        bus.start = 1'b0;
        tick(1'b1, 8'h01, 8'h44);
        tick(1'b1, 8'h02, 8'h81);
        bus.stop = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.stop = 1'b0;
        queue_empty("phase3_queue");

        // Phase 4: self-loop at pc 5
        load(8'h05, 8'hC4);
        bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h06);
        bus.start = 1'b0;
        tick(1'b1, 8'h01, 8'h44);
        tick(1'b1, 8'h02, 8'h81);
        tick(1'b1, 8'h03, 8'h01);
        tick(1'b1, 8'h04, 8'h02);
        tick(1'b1, 8'h05, 8'hC4);
        bus.reg0 = 8'h05;
        tick(1'b0, 8'h00, 8'h00);
        check1("halt5_halted", bus.halted, 1'b1);
        check8("halt5_inst", bus.inst, 8'h00);
        check8("halt5_pc", bus.pc, 8'h05);
        bus.stop = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.stop = 1'b0;
        check1("halt5_stop", bus.halted, 1'b0);
        queue_empty("phase4_queue");

        // Phase 5: all-zero store, 257 fetches wrap 255 -> 0
        for (int a = 0; a < 256; a++) load(8'(a), 8'h00);
        bus.start = 1'b1;
        tick(1'b1, 8'h00, 8'h00);
        bus.start = 1'b0;
        for (int i = 1; i <= 256; i++) tick(1'b1, 8'(i), 8'h00);
        check1("wrap_still_run", bus.inst_valid, 1'b1);
        check1("wrap_not_halted", bus.halted, 1'b0);
        check8("wrap_pc", bus.pc, 8'h00);
        bus.stop = 1'b1;
        tick(1'b0, 8'h00, 8'h00);
        bus.stop = 1'b0;
        check1("wrap_stop_valid", bus.inst_valid, 1'b0);
        queue_empty("phase5_queue");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and program-memory stage that sits directly upstream of `Calculations` and drives its `inst` byte each cycle. It holds a 256-byte program store, steps the PC, and resolves condition instructions (op `2'b11`) against register values fed back from the register file, redirecting the PC to `reg0` when the condition holds. A small run-control state machine gates program loading, execution and halting.

## Interface
Parameters:
- `DEPTH`, 256: program store entries; must equal 2**8 (PC is 8 bits).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  IDLE→RUN request, PC restarts at 0.
- `stop`  in  1  RUN/HALT→IDLE request.
- `prog_we`  in  1  program-store write strobe, honoured only in IDLE.
- `prog_addr`  in  8  write address.
- `prog_data`  in  8  write data.
- `reg0`  in  8  current register 0 value (jump target).
- `reg3`  in  8  current register 3 value (condition operand, signed).
- `inst`  out  8  instruction to `Calculations`; `8'h00` when not RUN.
- `inst_valid`  out  1  high only in RUN.
- `pc`  out  8  current program counter.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, RUN, HALT.
- IDLE: `prog_we` writes `prog_data` to `mem[prog_addr]` at the edge. `start` → RUN with `pc`=0. Write and `start` in the same cycle: write lands, RUN begins next cycle and fetch sees the new byte.
- RUN: `inst` = `mem[pc]` (asynchronous read), `inst_valid`=1. Writes ignored.
- Next PC in RUN: if `inst[7:6]==2'b11` and condition true → `reg0`; else `pc+1` mod 256 (255→0 wraps, no halt).
- Condition code `inst[2:0]`, `reg3` as signed 8-bit: 000 never, 001 ==0, 010 <0, 011 <=0, 100 always, 101 !=0, 110 >=0, 111 >0. `inst[5:3]` ignored.
- Taken jump with `reg0 == pc` → HALT (self-loop); `pc` holds.
- HALT: `inst`=0, `inst_valid`=0, `halted`=1, PC frozen. `stop` → IDLE. `start` ignored.
- `stop` in RUN → IDLE at next edge; instruction on `inst` that cycle is still valid, PC not advanced. `stop` has priority over jump/halt.
- `start` ignored outside IDLE; `stop` ignored in IDLE.

## Timing
- Reset (`rst`=0 at edge): state IDLE, `pc`=0, `inst`=0, `inst_valid`=0, `halted`=0. Program store not reset; contents persist across reset.
- Reset mid-RUN: next cycle IDLE, `pc`=0, no further instructions issued.
- `inst` is combinational from `pc` and state; `reg0`/`reg3` sampled at the edge ending the cycle in which the condition instruction is presented (zero-cycle branch resolution, no delay slot).
- One instruction per cycle in RUN; `start` asserted at edge N → first `inst_valid` in cycle N+1.
- `pc` output is the registered value, updates one edge after the decision.

## Structure
- Package `fetch_pkg`: state enum (IDLE/RUN/HALT), condition-code enum (8 codes above), opcode constant `OP_COND = 2'b11`.
- Sub-module `condition_unit`: combinational, inputs `code[2:0]`, `value[7:0]`, output `take`; reused by any later conditional stage.
- Top holds store array, PC register, FSM.

## Test plan
- Load `mem[0..2]` = `8'h05, 8'h44, 8'h81` in IDLE, `start` → cycles 1-3 show those bytes with `inst_valid`=1, `pc` 0,1,2.
- `mem[3]`=`8'hC4` (always), `reg0`=`8'h10` → next `pc`=`8'h10`; `8'hC1` with `reg3`=1 → `pc`=4 (not taken); `reg3`=0 → taken.
- Signed checks: code 010 with `reg3`=`8'h80` taken, `8'h7F` not; code 111 with `8'h01` taken, `8'h00` not.
- Fill store with `8'h00`, run 257 cycles → `pc` wraps 255→0, stays RUN.
- `mem[5]`=`8'hC4`, `reg0`=5 at `pc`=5 → HALT, `halted`=1, `inst`=0; `stop` → IDLE; `prog_we` during RUN leaves store unchanged.
- Drop `rst` mid-RUN at `pc`=7 → next cycle IDLE, `pc`=0, store contents intact on re-`start`.
